alu_lockstep_pair: RTL and testbench
====================================

Name: alu_lockstep_pair

Overview:
- Parametrised successor to the fixed 4-bit dual ALU/XOR comparator.
- Two identical WIDTH-bit ALU lanes sit behind a valid/ready handshake and a 2-stage pipeline.
- Lockstep mode: both lanes compute the same operation and are cross-checked, with a saturating mismatch counter and a sticky error flag. Independent mode: the lanes run separate operations.
- Sits between io_in/io_out and the user-project wrapper; also readable through LA bits.

Parameters:
- WIDTH, 4, operand/result width per lane (2..32).
- CNT_W, 8, mismatch counter width.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous assert, active-low (0 = reset).
- mode_lock  in  1  1 = lockstep (lane 1 uses lane 0 operands), 0 = independent.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block accepts operand set.
- a0_i, b0_i  in  WIDTH  lane 0 operands.
- a1_i, b1_i  in  WIDTH  lane 1 operands (ignored in lockstep).
- sel0_i, sel1_i  in  2  lane op select (sel1_i ignored in lockstep).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- res0_o, res1_o  out  WIDTH  lane results.
- cy0_o, cy1_o  out  1  lane carry flags.
- diff_o  out  WIDTH  res0_o XOR res1_o.
- cy_diff_o  out  1  cy0_o XOR cy1_o.
- mismatch_o  out  1  lockstep and (diff_o != 0 or cy_diff_o).
- err_sticky_o  out  1  sticky error.
- err_clr_i  in  1  clears sticky flag and counter.
- mis_cnt_o  out  CNT_W  saturating mismatch count.

Behaviour:
- Ops:
  - 00 ADD: {cy,res} = a+b, WIDTH+1 bits.
  - 01 SUB: {cy,res} = a + ~b + 1; cy=1 means no borrow (a>=b).
  - 10 AND: cy=0.
  - 11 XOR: cy=0.
- Stage 1 (S1): registers operands, sels and mode on in_valid && in_ready.
- Stage 2 (S2): registers ALU results, diff and mismatch.
- Latency: exactly 2 cycles from accept to out_valid when out_ready is held high.
- Throughput: 1 per cycle.
- Handshake:
  - S2 loads when S1 is valid and (!out_valid || out_ready).
  - S1 loads when in_valid and (!s1_valid || S1 advancing).
  - in_ready = !s1_valid || S1 advancing (combinational from out_ready).
  - Held out_valid with out_ready=0: S2 contents and all outputs stable, no loss, no duplication.
- Lockstep: lane 1 datapath is driven from a0/b0/sel0, captured at S1. The mode bit travels with the data, so a mode change mid-flight affects only newly accepted sets.
- Counter/flag update only on the output handshake (out_valid && out_ready && mismatch_o):
  - mis_cnt_o increments, saturating at all-ones.
  - err_sticky_o sets.
  - Independent mode never updates either.
- err_clr_i in a cycle with no mismatch handshake: counter becomes 0, flag becomes 0.
- err_clr_i simultaneous with a mismatch handshake: counter becomes 1, flag becomes 1.
- Reset (asynchronous, any time including mid-transfer):
  - s1_valid, out_valid, mis_cnt_o and err_sticky_o go to 0.
  - res, cy, diff and mismatch registers go to 0.
  - in_ready is 1 after reset.
  - In-flight data is discarded.

Optional Feature:
- Macro ALU_FAULT_INJECT_EN.
- Defined: adds ports inj_en_i (1) and inj_mask_i (WIDTH). When inj_en_i=1 at the S2 load, lane 1 result is XORed with inj_mask_i before registering; carry is unaffected. Used to prove the checker path.
- Undefined: the ports do not exist and lane 1 is never modified.

Decomposition:
- Shared package alu_pkg:
  - op encodings ALU_ADD/SUB/AND/XOR (2-bit localparams).
  - ALU_SEL_W = 2.
- Sub-module alu_lane:
  - parameter WIDTH; inputs a, b, sel; outputs res, cy.
  - Combinational, instantiated twice; the pipeline/handshake/checker live in the top.

Test Plan:
- Reset then lockstep ADD, WIDTH=4, a0=9, b0=8, out_ready=1 -> 2 cycles later res0=res1=1, cy0=cy1=1, mismatch_o=0, mis_cnt_o=0.
- Independent SUB a0=3,b0=5 and XOR a1=0xA,b1=0x5 -> res0=0xE, cy0=0; res1=0xF, cy1=0; diff_o=0x1; mismatch_o=0; counter unchanged.
- Backpressure: stream 4 sets with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted; outputs stable; all 4 delivered in order once released.
- ALU_FAULT_INJECT_EN, lockstep AND, inj_mask=0x4 for 3 handshakes -> mismatch_o=1 each; mis_cnt_o=3; err_sticky_o=1; CNT_W=2 with 5 faults saturates at 3.
- err_clr_i asserted on the same cycle as a mismatch handshake -> mis_cnt_o=1, err_sticky_o=1; next cycle clr alone -> 0, 0.
- wb_rst_i pulled low while out_valid=1 and S1 full -> out_valid=0, counter 0 immediately; after release first new result appears 2 cycles after accept.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings for the lockstep ALU pair
package alu_pkg;
  localparam int ALU_SEL_W = 2;
  localparam logic [ALU_SEL_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALU_SEL_W-1:0] ALU_AND = 2'b10;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR = 2'b11;
endpackage

// File: rtl/alu_lane.sv
// alu_lane: combinational WIDTH-bit ADD/SUB/AND/XOR lane with carry
module alu_lane import alu_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [ALU_SEL_W-1:0] sel,
  output logic [WIDTH-1:0]     res,
  output logic                 cy
);
  logic             w_sub;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH:0]   w_sum;
  assign w_sub = sel == ALU_SUB;
  assign w_bx  = w_sub ? ~b : b;
  // SUB as a + ~b + 1 so carry-out doubles as "no borrow"
  assign w_sum = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};
  assign res   = sel == ALU_AND ? a & b : sel == ALU_XOR ? a ^ b : w_sum[WIDTH-1:0];
  assign cy    = sel[1] ? 1'b0 : w_sum[WIDTH];
endmodule

// File: rtl/alu_lockstep_pair.sv
// alu_lockstep_pair: two pipelined ALU lanes, lockstep cross-check or independent ops
// Optional ALU_FAULT_INJECT_EN adds inj_en_i/inj_mask_i to corrupt lane 1 at S2 load.
module alu_lockstep_pair import alu_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
`ifdef ALU_FAULT_INJECT_EN
  input  logic                 inj_en_i,
  input  logic [WIDTH-1:0]     inj_mask_i,
`endif
  input  logic                 mode_lock,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a0_i,
  input  logic [WIDTH-1:0]     b0_i,
  input  logic [WIDTH-1:0]     a1_i,
  input  logic [WIDTH-1:0]     b1_i,
  input  logic [ALU_SEL_W-1:0] sel0_i,
  input  logic [ALU_SEL_W-1:0] sel1_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     res0_o,
  output logic [WIDTH-1:0]     res1_o,
  output logic                 cy0_o,
  output logic                 cy1_o,
  output logic [WIDTH-1:0]     diff_o,
  output logic                 cy_diff_o,
  output logic                 mismatch_o,
  output logic                 err_sticky_o,
  input  logic                 err_clr_i,
  output logic [CNT_W-1:0]     mis_cnt_o
);
  logic                 r_s1_valid, r_lock, r_out_valid;
  logic [WIDTH-1:0]     r_a0, r_b0, r_a1, r_b1;
  logic [ALU_SEL_W-1:0] r_sel0, r_sel1;
  logic [WIDTH-1:0]     r_res0, r_res1, r_diff;
  logic                 r_cy0, r_cy1, r_cy_diff, r_mis, r_err;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     w_res0, w_res1, w_res1_f, w_inj;
  logic                 w_cy0, w_cy1, w_s1_load, w_s2_load, w_mis_hs;
  alu_lane #(.WIDTH(WIDTH)) u_lane0 (.a(r_a0), .b(r_b0), .sel(r_sel0), .res(w_res0), .cy(w_cy0));
  alu_lane #(.WIDTH(WIDTH)) u_lane1 (.a(r_a1), .b(r_b1), .sel(r_sel1), .res(w_res1), .cy(w_cy1));
`ifdef ALU_FAULT_INJECT_EN
  assign w_inj = inj_en_i ? inj_mask_i : '0;
`else
  assign w_inj = '0;
`endif
  assign w_res1_f  = w_res1 ^ w_inj;
  assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_s1_load = in_valid && in_ready;
  assign w_mis_hs  = r_out_valid && out_ready && r_mis;
  // lockstep substitution happens at capture so the mode travels with the set
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_s1_valid <= 1'b0;
      r_lock     <= 1'b0;
      r_a0       <= '0;
      r_b0       <= '0;
      r_a1       <= '0;
      r_b1       <= '0;
      r_sel0     <= '0;
      r_sel1     <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= 1'b1;
      r_lock     <= mode_lock;
      r_a0       <= a0_i;
      r_b0       <= b0_i;
      r_sel0     <= sel0_i;
      r_a1       <= mode_lock ? a0_i : a1_i;
      r_b1       <= mode_lock ? b0_i : b1_i;
      r_sel1     <= mode_lock ? sel0_i : sel1_i;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_out_valid <= 1'b0;
      r_res0      <= '0;
      r_res1      <= '0;
      r_diff      <= '0;
      r_cy0       <= 1'b0;
      r_cy1       <= 1'b0;
      r_cy_diff   <= 1'b0;
      r_mis       <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_res0      <= w_res0;
      r_res1      <= w_res1_f;
      r_diff      <= w_res0 ^ w_res1_f;
      r_cy0       <= w_cy0;
      r_cy1       <= w_cy1;
      r_cy_diff   <= w_cy0 ^ w_cy1;
      r_mis       <= r_lock && ((w_res0 ^ w_res1_f) != '0 || (w_cy0 ^ w_cy1));
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
  // a mismatch handshake wins over clear, leaving a count of one
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_mis_hs) begin
      r_cnt <= err_clr_i ? CNT_W'(1) : &r_cnt ? r_cnt : r_cnt + 1'b1;
      r_err <= 1'b1;
    end else if (err_clr_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end
  end
  assign out_valid    = r_out_valid;
  assign res0_o       = r_res0;
  assign res1_o       = r_res1;
  assign cy0_o        = r_cy0;
  assign cy1_o        = r_cy1;
  assign diff_o       = r_diff;
  assign cy_diff_o    = r_cy_diff;
  assign mismatch_o   = r_mis;
  assign err_sticky_o = r_err;
  assign mis_cnt_o    = r_cnt;
endmodule

// File: tb/tb_alu_lockstep_pair.sv
// tb_alu_lockstep_pair: directed self-checking bench for alu_lockstep_pair (WIDTH=4)
module tb_alu_lockstep_pair;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       mode_lock = 1'b0, in_valid = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
  logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0] sel0 = '0, sel1 = '0;
  logic       in_ready, out_valid, cy0, cy1, cy_diff, mis, err;
  logic [3:0] res0, res1, diff;
  logic [7:0] cnt;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
`ifdef ALU_FAULT_INJECT_EN
  logic       inj_en = 1'b0;
  logic [3:0] inj_mask = '0;
  logic       in_ready2, out_valid2, cy0_2, cy1_2, cy_diff2, mis2, err2;
  logic [3:0] res0_2, res1_2, diff2;
  logic [1:0] cnt2;
  alu_lockstep_pair #(.WIDTH(4), .CNT_W(2)) u_dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .inj_en_i(inj_en), .inj_mask_i(inj_mask),
    .mode_lock(mode_lock), .in_valid(in_valid), .in_ready(in_ready2),
    .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1), .sel0_i(sel0), .sel1_i(sel1),
    .out_valid(out_valid2), .out_ready(out_ready), .res0_o(res0_2), .res1_o(res1_2),
    .cy0_o(cy0_2), .cy1_o(cy1_2), .diff_o(diff2), .cy_diff_o(cy_diff2),
    .mismatch_o(mis2), .err_sticky_o(err2), .err_clr_i(err_clr), .mis_cnt_o(cnt2));
`endif
  alu_lockstep_pair #(.WIDTH(4), .CNT_W(8)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
`ifdef ALU_FAULT_INJECT_EN
    .inj_en_i(inj_en), .inj_mask_i(inj_mask),
`endif
    .mode_lock(mode_lock), .in_valid(in_valid), .in_ready(in_ready),
    .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1), .sel0_i(sel0), .sel1_i(sel1),
    .out_valid(out_valid), .out_ready(out_ready), .res0_o(res0), .res1_o(res1),
    .cy0_o(cy0), .cy1_o(cy1), .diff_o(diff), .cy_diff_o(cy_diff),
    .mismatch_o(mis), .err_sticky_o(err), .err_clr_i(err_clr), .mis_cnt_o(cnt));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // accept one set, wait for its result, leave it presented (handshake on next edge)
  task automatic issue();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    #2;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_chk++; if (cnt !== 8'd0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_err got %0d/%0b want 0/0", cnt, err); end
    n_chk++; if (res0 !== 4'd0 || diff !== 4'd0 || mis !== 1'b0) begin n_fail++; $display("FAIL reset_regs got res0=%h diff=%h mis=%b want 0", res0, diff, mis); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_lock_add();
    out_ready = 1'b1; mode_lock = 1'b1;
    a0 = 4'd9; b0 = 4'd8; sel0 = 2'b00; a1 = 4'd3; b1 = 4'd6; sel1 = 2'b11;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency1 out_valid got %0b want 0", out_valid); end
    tick();
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency2 out_valid got %0b want 1", out_valid); end
    n_chk++; if (res0 !== 4'd1 || res1 !== 4'd1) begin n_fail++; $display("FAIL add_res got %h/%h want 1/1", res0, res1); end
    n_chk++; if (cy0 !== 1'b1 || cy1 !== 1'b1) begin n_fail++; $display("FAIL add_cy got %b/%b want 1/1", cy0, cy1); end
    n_chk++; if (mis !== 1'b0 || cnt !== 8'd0) begin n_fail++; $display("FAIL add_mis got %b cnt=%0d want 0 cnt=0", mis, cnt); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain out_valid got %0b want 0", out_valid); end
  endtask
  task automatic test_independent();
    mode_lock = 1'b0;
    a0 = 4'd3; b0 = 4'd5; sel0 = 2'b01; a1 = 4'hA; b1 = 4'h5; sel1 = 2'b11;
    issue();
    n_chk++; if (res0 !== 4'hE || cy0 !== 1'b0) begin n_fail++; $display("FAIL ind_lane0 got %h cy=%b want e cy=0", res0, cy0); end
    n_chk++; if (res1 !== 4'hF || cy1 !== 1'b0) begin n_fail++; $display("FAIL ind_lane1 got %h cy=%b want f cy=0", res1, cy1); end
    n_chk++; if (diff !== 4'h1 || cy_diff !== 1'b0) begin n_fail++; $display("FAIL ind_diff got %h/%b want 1/0", diff, cy_diff); end
    n_chk++; if (mis !== 1'b0) begin n_fail++; $display("FAIL ind_mis got %b want 0", mis); end
    tick();
    n_chk++; if (cnt !== 8'd0 || err !== 1'b0) begin n_fail++; $display("FAIL ind_cnt got %0d/%b want 0/0", cnt, err); end
    a0 = 4'd7; b0 = 4'd2; sel0 = 2'b01; a1 = 4'hC; b1 = 4'hA; sel1 = 2'b10;
    issue();
    n_chk++; if (res0 !== 4'd5 || cy0 !== 1'b1 || res1 !== 4'h8 || cy1 !== 1'b0) begin n_fail++; $display("FAIL ind2 got %h/%b %h/%b want 5/1 8/0", res0, cy0, res1, cy1); end
    n_chk++; if (diff !== 4'hD || cy_diff !== 1'b1 || mis !== 1'b0) begin n_fail++; $display("FAIL ind2_diff got %h/%b mis=%b want d/1 mis=0", diff, cy_diff, mis); end
    tick();
  endtask
  // set k is lockstep ADD (k+1)+2, so its result is k+3
  task automatic test_backpressure();
    int n_acc = 0, n_out = 0;
    mode_lock = 1'b1; sel0 = 2'b00; b0 = 4'd2; out_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      out_ready = c >= 5;
      in_valid = n_acc < 4;
      a0 = 4'(n_acc + 1);
      #1;
      if (c == 4) begin
        n_chk++; if (n_acc != 2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall accepted=%0d in_ready=%b want 2/0", n_acc, in_ready); end
      end
      if (c >= 2 && c < 5) begin
        n_chk++; if (out_valid !== 1'b1 || res0 !== 4'd3 || res1 !== 4'd3) begin n_fail++; $display("FAIL bp_hold c=%0d got v=%b %h/%h want 1 3/3", c, out_valid, res0, res1); end
      end
      if (out_valid && out_ready) begin
        n_chk++; if (res0 !== 4'(n_out + 3) || res1 !== 4'(n_out + 3)) begin n_fail++; $display("FAIL bp_order #%0d got %h/%h want %h", n_out, res0, res1, 4'(n_out + 3)); end
        n_out++;
      end
      if (in_valid && in_ready) n_acc++;
      tick();
    end
    in_valid = 1'b0;
    n_chk++; if (n_out != 4 || n_acc != 4) begin n_fail++; $display("FAIL bp_count delivered=%0d accepted=%0d want 4/4", n_out, n_acc); end
  endtask
  task automatic test_clear_alone();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_chk++; if (cnt !== 8'd0 || err !== 1'b0) begin n_fail++; $display("FAIL clr_alone got %0d/%b want 0/0", cnt, err); end
  endtask
`ifdef ALU_FAULT_INJECT_EN
  task automatic test_fault_inject();
    mode_lock = 1'b1; out_ready = 1'b1; sel0 = 2'b10; a0 = 4'hF; b0 = 4'hF;
    inj_en = 1'b1; inj_mask = 4'h4;
    for (int k = 1; k <= 5; k++) begin
      issue();
      n_chk++; if (mis !== 1'b1 || diff !== 4'h4 || res1 !== 4'hB || cy_diff !== 1'b0) begin n_fail++; $display("FAIL inj_mis #%0d got mis=%b diff=%h res1=%h want 1 4 b", k, mis, diff, res1); end
      tick();
      if (k == 3) begin
        n_chk++; if (cnt !== 8'd3 || err !== 1'b1) begin n_fail++; $display("FAIL inj_cnt3 got %0d/%b want 3/1", cnt, err); end
      end
    end
    n_chk++; if (cnt !== 8'd5 || cnt2 !== 2'd3 || err2 !== 1'b1) begin n_fail++; $display("FAIL inj_sat got %0d/%0d want 5/3", cnt, cnt2); end
    issue();
    err_clr = 1'b1;
    tick();
    n_chk++; if (cnt !== 8'd1 || err !== 1'b1 || cnt2 !== 2'd1) begin n_fail++; $display("FAIL clr_with_hs got %0d/%b want 1/1", cnt, err); end
    tick();
    err_clr = 1'b0;
    n_chk++; if (cnt !== 8'd0 || err !== 1'b0) begin n_fail++; $display("FAIL clr_next got %0d/%b want 0/0", cnt, err); end
    inj_en = 1'b0;
    issue();
    tick();
    n_chk++; if (cnt !== 8'd0 || err !== 1'b0) begin n_fail++; $display("FAIL inj_off got %0d/%b want 0/0", cnt, err); end
    mode_lock = 1'b0; inj_en = 1'b1;
    issue();
    tick();
    inj_en = 1'b0;
    n_chk++; if (cnt !== 8'd0 || err !== 1'b0) begin n_fail++; $display("FAIL inj_indep got %0d/%b want 0/0", cnt, err); end
  endtask
`endif
  task automatic test_reset_midflight();
    mode_lock = 1'b1; sel0 = 2'b00; out_ready = 1'b0;
    a0 = 4'd1; b0 = 4'd1; in_valid = 1'b1;
    tick();
    a0 = 4'd2;
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full got v=%b rdy=%b want 1/0", out_valid, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || cnt !== 8'd0 || res0 !== 4'd0) begin n_fail++; $display("FAIL mid_reset got v=%b rdy=%b cnt=%0d res0=%h want 0 1 0 0", out_valid, in_ready, cnt, res0); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1; a0 = 4'd6; b0 = 4'd7;
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale out_valid got %b want 0", out_valid); end
    issue();
    n_chk++; if (out_valid !== 1'b1 || res0 !== 4'hD || cy0 !== 1'b0) begin n_fail++; $display("FAIL mid_new got v=%b %h/%b want 1 d/0", out_valid, res0, cy0); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_dup out_valid got %b want 0", out_valid); end
  endtask
  initial begin
    test_reset();
    test_lock_add();
    test_independent();
    test_backpressure();
    test_clear_alone();
`ifdef ALU_FAULT_INJECT_EN
    test_fault_inject();
`endif
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
